encoder_counter: RTL and testbench
==================================

ENCODER_COUNTER -- requirements
Module: encoder_counter

Interface
REQ-001 Parameter WIDTH, default 8, width of the count value.
REQ-002 Parameter STEPS_PER_DETENT, default 4, valid quadrature transitions per count change; legal values 1, 2, 4.
REQ-003 Parameter INCREMENT, default 1, amount added or subtracted per detent.
REQ-004 Parameter SATURATE, default 0; 1 = clamp at 0 and 2^WIDTH-1, 0 = modulo-2^WIDTH wrap.
REQ-005 Parameter RESET_VALUE, default 0, value loaded by reset and clear.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 reset_n  input  1  synchronous, active-low reset.
REQ-008 a  input  1  debounced encoder channel A, synchronous to clk.
REQ-009 b  input  1  debounced encoder channel B, synchronous to clk.
REQ-010 clr  input  1  synchronous clear of value and sub-position.
REQ-011 value  output  WIDTH  registered count.
REQ-012 step  output  1  one-cycle pulse on each detent completion.
REQ-013 dir  output  1  direction of last detent; 1 = up, held between detents.
REQ-014 err  output  1  one-cycle pulse on illegal transition.

Function
REQ-015 Register prev_ab holds {a,b} sampled on the previous edge; updated every non-reset cycle, including clr cycles.
REQ-016 Transition decode on {prev_ab, a, b}: 00->01, 01->11, 11->10, 10->00 = up; reverse order = down; no change = idle; 00<->11 or 01<->10 = illegal.
REQ-017 Signed sub-position register, range -(STEPS_PER_DETENT) to +(STEPS_PER_DETENT): up adds 1, down subtracts 1, idle/illegal hold.
REQ-018 When updated sub-position reaches +STEPS_PER_DETENT: value increases by INCREMENT, sub-position returns to 0, step=1, dir=1, same edge.
REQ-019 When updated sub-position reaches -STEPS_PER_DETENT: value decreases by INCREMENT, sub-position returns to 0, step=1, dir=0, same edge.
REQ-020 Latency: value, step, dir, err change on the same edge that first samples the new {a,b}; visible for the following cycle.
REQ-021 Direction reversal mid-detent unwinds the sub-position; no count change until threshold reached.
REQ-022 Illegal transition: err=1 one cycle, value and sub-position unchanged, prev_ab takes new sample.
REQ-023 SATURATE=0: arithmetic modulo 2^WIDTH (255+1 -> 0, 0-1 -> 255 at WIDTH 8, INCREMENT 1).
REQ-024 SATURATE=1: up result above 2^WIDTH-1 clamps to 2^WIDTH-1, down result below 0 clamps to 0; step still pulses, dir still updates.
REQ-025 clr=1: value=RESET_VALUE, sub-position=0, step=0, err=0, dir unchanged; clr overrides any simultaneous transition.
REQ-026 step and err never asserted in the same cycle; step is 0 on idle cycles.

Reset
REQ-027 On reset_n=0 at an edge: value=RESET_VALUE, sub-position=0, step=0, err=0, dir=1.
REQ-028 On reset_n=0 prev_ab loads current {a,b}, so first post-reset cycle never counts or flags err.
REQ-029 Reset asserted mid-detent discards the partial sub-position.

Structure
REQ-030 Shared package rgb_mixer_pkg holds quadrature phase constants (00, 01, 11, 10) and decode result codes (IDLE, UP, DOWN, ILLEGAL).
REQ-031 One combinational sub-module quad_step_decode maps {prev_ab, a, b} to the decode result code; all state stays in encoder_counter.

Verification
REQ-032 Reset, then 4 up transitions 00->01->11->10->00 at default params -> value 0->1, single step pulse on 4th edge, dir=1.
REQ-033 value=0, SATURATE=0, one full down detent -> value=255, dir=0; SATURATE=1 same stimulus -> value stays 0, step pulses.
REQ-034 Two up transitions then two down transitions -> value unchanged, no step, sub-position back to 0.
REQ-035 Transition 00->11 -> err pulse for exactly one cycle, value and sub-position unchanged.
REQ-036 clr=1 on the edge completing an up detent from value=7 -> value=RESET_VALUE (0), no step.
REQ-037 reset_n low after 3 up transitions, release, 1 more up transition -> value stays RESET_VALUE, no step.

Source files
------------

// File: rtl/rgb_mixer_pkg.sv
// -----------------------------------------------------------------------------
// rgb_mixer_pkg
// Shared definitions for the quadrature encoder counter.
//   - PH_* : the four quadrature phases of {a,b}, listed in counting-up order
//   - dec_e: result of decoding one {prev_ab, a, b} transition
//   - phase_up(): the phase that follows a given phase when rotating up
// -----------------------------------------------------------------------------
package rgb_mixer_pkg;

   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_01 = 2'b01;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_10 = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      UP      = 2'b01,
      DOWN    = 2'b10,
      ILLEGAL = 2'b11
   } dec_e;

   // Gray sequence 00 -> 01 -> 11 -> 10 -> 00 is the "up" rotation.
   function automatic logic [1:0] phase_up(input logic [1:0] ph);
      logic [1:0] nxt;
      case (ph)
         PH_00:   nxt = PH_01;
         PH_01:   nxt = PH_11;
         PH_11:   nxt = PH_10;
         PH_10:   nxt = PH_00;
         default: nxt = PH_00;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/quad_step_decode.sv
// -----------------------------------------------------------------------------
// quad_step_decode
// Purely combinational classification of one quadrature transition.
// Ports:
//   prev_ab : input  [1:0]  {a,b} sampled on the previous edge
//   cur_ab  : input  [1:0]  {a,b} as seen at the current edge
//   result  : output dec_e  IDLE / UP / DOWN / ILLEGAL
// A move of two phases (00<->11, 01<->10) cannot be attributed to a direction
// and is reported as ILLEGAL.
// -----------------------------------------------------------------------------
module quad_step_decode
   import rgb_mixer_pkg::*;
(
   input  logic [1:0] prev_ab,
   input  logic [1:0] cur_ab,
   output dec_e       result
);

   // Classify the transition relative to the up-rotation sequence.
   always_comb begin
      result = IDLE;
      if (cur_ab == prev_ab) begin
         result = IDLE;
      end else if (cur_ab == phase_up(prev_ab)) begin
         result = UP;
      end else if (prev_ab == phase_up(cur_ab)) begin
         result = DOWN;
      end else begin
         result = ILLEGAL;
      end
   end

endmodule

// File: rtl/encoder_counter.sv
// -----------------------------------------------------------------------------
// encoder_counter
// Quadrature encoder detent counter with wrap or saturating arithmetic.
// Parameters:
//   WIDTH            width of value
//   STEPS_PER_DETENT valid transitions per count change (1, 2 or 4)
//   INCREMENT        amount added/subtracted per detent
//   SATURATE         1 = clamp to [0, 2^WIDTH-1], 0 = modulo wrap
//   RESET_VALUE      value loaded by reset_n and clr
// Ports:
//   clk     : input   clock, all state on rising edge
//   reset_n : input   synchronous active-low reset
//   a, b    : input   debounced encoder channels, synchronous to clk
//   clr     : input   synchronous clear of value and sub-position
//   value   : output  registered count
//   step    : output  one-cycle pulse per completed detent
//   dir     : output  direction of last detent (1 = up), held between detents
//   err     : output  one-cycle pulse on an illegal transition
// -----------------------------------------------------------------------------
module encoder_counter
   import rgb_mixer_pkg::*;
#(
   parameter int WIDTH            = 8,
   parameter int STEPS_PER_DETENT = 4,
   parameter int INCREMENT        = 1,
   parameter int SATURATE         = 0,
   parameter int RESET_VALUE      = 0
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             a,
   input  logic             b,
   input  logic             clr,
   output logic [WIDTH-1:0] value,
   output logic             step,
   output logic             dir,
   output logic             err
);

   // Sub-position spans -4..+4 at most, which fits a 4-bit signed register.
   localparam logic signed [3:0] STEPS_S = 4'(STEPS_PER_DETENT);
   localparam logic [WIDTH-1:0]  RST_VAL = WIDTH'(RESET_VALUE);
   localparam logic [WIDTH:0]    INC_EXT = (WIDTH+1)'(INCREMENT);

   logic [1:0]        prev_ab_r;
   logic signed [3:0] sub_r;
   logic [WIDTH-1:0]  value_r;
   logic              step_r;
   logic              dir_r;
   logic              err_r;

   dec_e              dec_s;
   logic signed [3:0] sub_inc_s;
   logic signed [3:0] sub_dec_s;
   logic [WIDTH:0]    sum_s;
   logic [WIDTH:0]    diff_s;
   logic [WIDTH-1:0]  value_up_s;
   logic [WIDTH-1:0]  value_dn_s;
   logic signed [3:0] sub_nxt_s;
   logic [WIDTH-1:0]  value_nxt_s;
   logic              step_nxt_s;
   logic              dir_nxt_s;
   logic              err_nxt_s;

   quad_step_decode u_decode (
      .prev_ab (prev_ab_r),
      .cur_ab  ({a, b}),
      .result  (dec_s)
   );

   assign sub_inc_s = sub_r + 4'sd1;
   assign sub_dec_s = sub_r - 4'sd1;

   // The extra MSB of sum/diff is the carry/borrow used for clamping.
   assign sum_s  = {1'b0, value_r} + INC_EXT;
   assign diff_s = {1'b0, value_r} - INC_EXT;

   // Candidate count after an up or down detent, wrapped or clamped.
   always_comb begin
      value_up_s = sum_s[WIDTH-1:0];
      value_dn_s = diff_s[WIDTH-1:0];
      if ((SATURATE != 0) && sum_s[WIDTH]) begin
         value_up_s = '1;
      end else begin
         value_up_s = sum_s[WIDTH-1:0];
      end
      if ((SATURATE != 0) && diff_s[WIDTH]) begin
         value_dn_s = '0;
      end else begin
         value_dn_s = diff_s[WIDTH-1:0];
      end
   end

   // Next-state for sub-position and outputs from the decoded transition.
   always_comb begin
      sub_nxt_s   = sub_r;
      value_nxt_s = value_r;
      step_nxt_s  = 1'b0;
      dir_nxt_s   = dir_r;
      err_nxt_s   = 1'b0;
      case (dec_s)
         UP: begin
            if (sub_inc_s == STEPS_S) begin
               value_nxt_s = value_up_s;
               sub_nxt_s   = 4'sd0;
               step_nxt_s  = 1'b1;
               dir_nxt_s   = 1'b1;
            end else begin
               sub_nxt_s   = sub_inc_s;
            end
         end
         DOWN: begin
            if (sub_dec_s == -STEPS_S) begin
               value_nxt_s = value_dn_s;
               sub_nxt_s   = 4'sd0;
               step_nxt_s  = 1'b1;
               dir_nxt_s   = 1'b0;
            end else begin
               sub_nxt_s   = sub_dec_s;
            end
         end
         ILLEGAL: begin
            err_nxt_s = 1'b1;
         end
         IDLE: begin
            sub_nxt_s = sub_r;
         end
         default: begin
            sub_nxt_s = sub_r;
         end
      endcase
   end

   // State register; prev_ab tracks the inputs even during reset and clr so
   // the first following cycle compares against a fresh sample.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prev_ab_r <= {a, b};
         sub_r     <= 4'sd0;
         value_r   <= RST_VAL;
         step_r    <= 1'b0;
         err_r     <= 1'b0;
         dir_r     <= 1'b1;
      end else if (clr) begin
         prev_ab_r <= {a, b};
         sub_r     <= 4'sd0;
         value_r   <= RST_VAL;
         step_r    <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         prev_ab_r <= {a, b};
         sub_r     <= sub_nxt_s;
         value_r   <= value_nxt_s;
         step_r    <= step_nxt_s;
         err_r     <= err_nxt_s;
         dir_r     <= dir_nxt_s;
      end
   end

   assign value = value_r;
   assign step  = step_r;
   assign dir   = dir_r;
   assign err   = err_r;

endmodule

// File: tb/tb_encoder_counter.sv
// -----------------------------------------------------------------------------
// tb_encoder_counter
// Two instances share all inputs: one wrapping (default), one saturating.
// A phase-index model predicts every output each cycle; directed sequences
// add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_encoder_counter;

   localparam int W     = 8;
   localparam int STEPS = 4;
   localparam int INC   = 1;
   localparam int RV    = 0;
   localparam int MAXV  = (1 << W) - 1;

   logic         clk;
   logic         reset_n;
   logic         a;
   logic         b;
   logic         clr;
   logic [W-1:0] value_w;
   logic         step_w;
   logic         dir_w;
   logic         err_w;
   logic [W-1:0] value_s;
   logic         step_s;
   logic         dir_s;
   logic         err_s;

   int vectors  = 0;
   int miscomp  = 0;
   bit check_en = 1'b0;

   encoder_counter #(.WIDTH(W), .STEPS_PER_DETENT(STEPS), .INCREMENT(INC),
                     .SATURATE(0), .RESET_VALUE(RV)) dut (
      .clk(clk), .reset_n(reset_n), .a(a), .b(b), .clr(clr),
      .value(value_w), .step(step_w), .dir(dir_w), .err(err_w));

   encoder_counter #(.WIDTH(W), .STEPS_PER_DETENT(STEPS), .INCREMENT(INC),
                     .SATURATE(1), .RESET_VALUE(RV)) dut_sat (
      .clk(clk), .reset_n(reset_n), .a(a), .b(b), .clr(clr),
      .value(value_s), .step(step_s), .dir(dir_s), .err(err_s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int prev;
      int sub;
      int vwrap;
      int vsat;
      int step;
      int dir;
      int err;
   } model_t;

   model_t m;

   // Position of a phase on the up-rotation circle 00,01,11,10.
   function automatic int ph_idx(input logic [1:0] ab);
      int r;
      case (ab)
         2'b00:   r = 0;
         2'b01:   r = 1;
         2'b11:   r = 2;
         default: r = 3;
      endcase
      return r;
   endfunction

   function automatic model_t model_next(input model_t cur, input logic [1:0] ab,
                                         input logic c, input logic rn);
      model_t n;
      int d;
      n = cur;
      n.step = 0;
      n.err  = 0;
      if (!rn) begin
         n.prev = ph_idx(ab); n.sub = 0; n.vwrap = RV; n.vsat = RV; n.dir = 1;
      end else begin
         d = (ph_idx(ab) - cur.prev + 4) % 4;
         n.prev = ph_idx(ab);
         if (c) begin
            n.sub = 0; n.vwrap = RV; n.vsat = RV;
         end else if (d == 2) begin
            n.err = 1;
         end else if (d != 0) begin
            n.sub = cur.sub + ((d == 1) ? 1 : -1);
            if (n.sub == STEPS) begin
               n.sub = 0; n.step = 1; n.dir = 1;
               n.vwrap = (cur.vwrap + INC) % (MAXV + 1);
               n.vsat  = (cur.vsat + INC > MAXV) ? MAXV : cur.vsat + INC;
            end else if (n.sub == -STEPS) begin
               n.sub = 0; n.step = 1; n.dir = 0;
               n.vwrap = (cur.vwrap - INC + (MAXV + 1)) % (MAXV + 1);
               n.vsat  = (cur.vsat - INC < 0) ? 0 : cur.vsat - INC;
            end
         end
      end
      return n;
   endfunction

   // Model advances on the same edge the DUT samples its inputs.
   always @(posedge clk) m <= model_next(m, {a, b}, clr, reset_n);

   task automatic cmp(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscomp++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Every-cycle comparison against the model, half a cycle after the edge.
   always @(negedge clk) begin
      if (check_en) begin
         cmp("wrap.value", int'(value_w), m.vwrap);
         cmp("wrap.step",  int'(step_w),  m.step);
         cmp("wrap.dir",   int'(dir_w),   m.dir);
         cmp("wrap.err",   int'(err_w),   m.err);
         cmp("sat.value",  int'(value_s), m.vsat);
         cmp("sat.step",   int'(step_s),  m.step);
         cmp("sat.dir",    int'(dir_s),   m.dir);
         cmp("sat.err",    int'(err_s),   m.err);
      end
   end

   // Inputs change shortly after an edge and are sampled by the next one.
   task automatic drive(input logic [1:0] ab, input logic c, input logic rn);
      @(posedge clk);
      #2;
      {a, b}  = ab;
      clr     = c;
      reset_n = rn;
   endtask

   // Wait for the edge that samples the last driven inputs.
   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(2'b00, 1'b0, 1'b0);
      drive(2'b00, 1'b0, 1'b1);
   endtask

   task automatic up_detent();
      drive(2'b01, 1'b0, 1'b1);
      drive(2'b11, 1'b0, 1'b1);
      drive(2'b10, 1'b0, 1'b1);
      drive(2'b00, 1'b0, 1'b1);
   endtask

   initial begin
      {a, b}  = 2'b00;
      clr     = 1'b0;
      reset_n = 1'b0;
      drive(2'b00, 1'b0, 1'b0);
      drive(2'b00, 1'b0, 1'b1);
      settle();
      check_en = 1'b1;
      cmp("reset.value", int'(value_w), 0);
      cmp("reset.dir",   int'(dir_w),   1);
      cmp("reset.step",  int'(step_w),  0);
      cmp("reset.err",   int'(err_w),   0);

      // One full up detent: single step on the fourth transition.
      drive(2'b01, 1'b0, 1'b1);
      settle();
      cmp("up1.step", int'(step_w), 0);
      drive(2'b11, 1'b0, 1'b1);
      drive(2'b10, 1'b0, 1'b1);
      drive(2'b00, 1'b0, 1'b1);
      settle();
      cmp("up4.value", int'(value_w), 1);
      cmp("up4.step",  int'(step_w),  1);
      cmp("up4.dir",   int'(dir_w),   1);

      // Down detent from 0: wrap to 255, saturating copy stays 0.
      do_reset();
      drive(2'b10, 1'b0, 1'b1);
      drive(2'b11, 1'b0, 1'b1);
      drive(2'b01, 1'b0, 1'b1);
      drive(2'b00, 1'b0, 1'b1);
      settle();
      cmp("down.wrap.value", int'(value_w), 255);
      cmp("down.wrap.dir",   int'(dir_w),   0);
      cmp("down.sat.value",  int'(value_s), 0);
      cmp("down.sat.step",   int'(step_s),  1);

      // Two up then two down: no step, sub-position back to zero.
      drive(2'b01, 1'b0, 1'b1);
      drive(2'b11, 1'b0, 1'b1);
      drive(2'b01, 1'b0, 1'b1);
      drive(2'b00, 1'b0, 1'b1);
      settle();
      cmp("unwind.value", int'(value_w), 255);
      cmp("unwind.step",  int'(step_w),  0);
      up_detent();
      settle();
      cmp("wrap255.value", int'(value_w), 0);
      cmp("sat.value1",    int'(value_s), 1);

      // Illegal 00->11: one-cycle err, nothing else moves.
      drive(2'b01, 1'b0, 1'b1);
      drive(2'b00, 1'b0, 1'b1);
      drive(2'b11, 1'b0, 1'b1);
      settle();
      cmp("illegal.err",   int'(err_w),   1);
      cmp("illegal.value", int'(value_w), 0);
      settle();
      cmp("illegal.err_clear", int'(err_w), 0);
      drive(2'b10, 1'b0, 1'b1);
      drive(2'b00, 1'b0, 1'b1);
      drive(2'b01, 1'b0, 1'b1);
      drive(2'b11, 1'b0, 1'b1);
      settle();
      cmp("post_illegal.value", int'(value_w), 1);
      drive(2'b01, 1'b0, 1'b1);
      drive(2'b10, 1'b0, 1'b1);
      settle();
      cmp("illegal2.err", int'(err_w), 1);

      // clr on the completing edge of a detent from 7.
      do_reset();
      for (int i = 0; i < 7; i++) up_detent();
      settle();
      cmp("seven.value", int'(value_w), 7);
      drive(2'b01, 1'b0, 1'b1);
      drive(2'b11, 1'b0, 1'b1);
      drive(2'b10, 1'b0, 1'b1);
      drive(2'b00, 1'b1, 1'b1);
      settle();
      cmp("clr.value", int'(value_w), 0);
      cmp("clr.step",  int'(step_w),  0);
      cmp("clr.dir",   int'(dir_w),   1);
      drive(2'b00, 1'b0, 1'b1);

      // Reset mid-detent discards three pending transitions.
      drive(2'b01, 1'b0, 1'b1);
      drive(2'b11, 1'b0, 1'b1);
      drive(2'b10, 1'b0, 1'b1);
      drive(2'b00, 1'b0, 1'b0);
      drive(2'b00, 1'b0, 1'b1);
      settle();
      cmp("rst_first.err",  int'(err_w),  0);
      drive(2'b01, 1'b0, 1'b1);
      settle();
      cmp("rst_mid.value", int'(value_w), 0);
      cmp("rst_mid.step",  int'(step_w),  0);

      // Saturation at the top: from 254, two up detents clamp at 255.
      do_reset();
      for (int i = 0; i < 254; i++) up_detent();
      up_detent();
      up_detent();
      settle();
      cmp("sat.top",  int'(value_s), 255);
      cmp("wrap.top", int'(value_w), 0);

      settle();
      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
      $finish;
   end

endmodule
